// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl
//   Sequencer that owns the handshake between the decoder, the register
//   file and the ALU. It takes one decoded operation at a time. For LI it
//   issues an address latch with the immediate store. For ALU operations it
//   latches the addresses, pulses the ALU start, waits for the result and
//   strobes the write-back. It then waits for the register file acknowledge
//   and reports completion. Each wait is bounded by TIMEOUT cycles.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        decoder handshake; ready only while idle
//   req_op/rs1/rs2/rd/imm/alu_op  operation fields, captured on acceptance
//   rs_addr_valid, rs1_rs2_rd  address latch strobe and {rs1,rs2,rd}
//   rs_store, imme_data        immediate store enable and value
//   rd_wr_en                   ALU result write-back strobe
//   op_done                    register file acknowledge
//   alu_start, alu_op          ALU start pulse and function code
//   alu_done                   ALU result valid
//   busy                       controller is not idle
//   cmpl_valid/err/rd          completion pulse, abort flag, destination
//   err_timeout, err_clr       sticky timeout flag and its clear
//   instr_count                operations retired without error
module regfile_seq_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [4:0]       req_rd,
    input  logic [31:0]      req_imm,
    input  logic [3:0]       req_alu_op,
    output logic             rs_addr_valid,
    output logic [14:0]      rs1_rs2_rd,
    output logic             rs_store,
    output logic [31:0]      imme_data,
    output logic             rd_wr_en,
    input  logic             op_done,
    output logic             alu_start,
    output logic [3:0]       alu_op,
    input  logic             alu_done,
    output logic             busy,
    output logic             cmpl_valid,
    output logic             cmpl_err,
    output logic [4:0]       cmpl_rd,
    output logic             err_timeout,
    input  logic             err_clr,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ALU_START,
        S_ALU_WAIT,
        S_WB,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [4:0]    h_rs1, h_rs2, h_rd;
    logic [31:0]   h_imm;
    logic [3:0]    h_alu_op;
    logic          h_li;
    logic          h_err;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          tmo_last;

    assign tmo_last = (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) state_nxt = req_op[1] ? S_DONE : S_ISSUE;
            end
            S_ISSUE:     state_nxt = h_li ? S_WAIT_ACK : S_ALU_START;
            S_ALU_START: state_nxt = S_ALU_WAIT;
            S_ALU_WAIT: begin
                if (alu_done) begin
                    state_nxt = S_WB;
                end else if (tmo_last) begin
                    state_nxt = S_DONE;
                    tmo_hit   = 1'b1;
                end
            end
            S_WB:        state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (op_done) begin
                    state_nxt = S_DONE;
                end else if (tmo_last) begin
                    state_nxt = S_DONE;
                    tmo_hit   = 1'b1;
                end
            end
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            h_rs1       <= '0;
            h_rs2       <= '0;
            h_rd        <= '0;
            h_imm       <= '0;
            h_alu_op    <= '0;
            h_li        <= 1'b0;
            h_err       <= 1'b0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && req_valid) begin
                h_rs1    <= req_rs1;
                h_rs2    <= req_rs2;
                h_rd     <= req_rd;
                h_imm    <= req_imm;
                h_alu_op <= req_alu_op;
                h_li     <= req_op[0];
                h_err    <= req_op[1];
            end else if (tmo_hit) begin
                h_err <= 1'b1;
            end

            // Counter restarts on every entry into a wait state and only
            // advances while staying in it without an event.
            if ((state == S_ALU_WAIT || state == S_WAIT_ACK) && state_nxt == state)
                tmo_cnt <= tmo_cnt + TW'(1);
            else
                tmo_cnt <= '0;

            // A timeout in the same cycle as err_clr leaves the flag set.
            if (tmo_hit)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;

            if (state == S_DONE && !h_err)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign req_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign rs_addr_valid = (state == S_ISSUE);
    assign rs_store      = (state == S_ISSUE) && h_li;
    assign rs1_rs2_rd    = {h_rs1, h_rs2, h_rd};
    assign imme_data     = h_imm;
    assign alu_start     = (state == S_ALU_START);
    assign alu_op        = h_alu_op;
    assign rd_wr_en      = (state == S_WB);
    assign cmpl_valid    = (state == S_DONE);
    assign cmpl_err      = (state == S_DONE) && h_err;
    assign cmpl_rd       = h_rd;

endmodule
